// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: request-master FSM state encoding and
// AXI response codes.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
  } axi_req_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Any response code other than OKAY is reported as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sram_req_master.sv
// Simple request/response port to AXI-Lite master bridge (one transaction
// outstanding), intended to drive axi_sram_controller.
// Optional feature: define AXI_SRAM_REQ_MASTER_ERR_EN to report non-OKAY
// bresp/rresp on resp_err; otherwise resp_err is tied low.
module axi_sram_req_master
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  // request side
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     req_data,
  // response side
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     resp_data,
  output logic                          resp_err,
  // write address
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // write data
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // write response
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // read
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  axi_req_state_e              state_q, state_d;
  logic                        rst_done_q, rst_done_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;

`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
  logic                        err_q, err_d;
  assign resp_err = err_q;
`else
  logic                        unused_resp_codes;
  assign unused_resp_codes = ^{m_axi_bresp, m_axi_rresp};
  assign resp_err          = 1'b0;
`endif

  // Handshake outputs decode directly from the registered state; AW and W
  // each drop independently once their own handshake has been seen.
  assign req_ready     = (state_q == IDLE) && rst_done_q;
  assign resp_valid    = (state_q == RESP);
  assign resp_data     = rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_rready  = (state_q == RD_DATA);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      rst_done_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rst_done_q <= rst_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    rst_done_d = 1'b1;
    addr_d     = addr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d    = req_addr;
          data_d    = req_data;
          rdata_d   = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
          err_d     = 1'b0;
`endif
          state_d   = req_we ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // Leave as soon as the last of the two handshakes completes.
        aw_done_d = aw_done_q || (m_axi_awvalid && m_axi_awready);
        w_done_d  = w_done_q  || (m_axi_wvalid  && m_axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
          err_d   = resp_is_err(m_axi_bresp);
`endif
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
          err_d   = resp_is_err(m_axi_rresp);
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_req_master.sv
// Self-checking bench for axi_sram_req_master with a behavioural AXI-Lite
// SRAM slave and a response scoreboard.
module tb_axi_sram_req_master;
  import axi_lite_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

`ifdef AXI_SRAM_REQ_MASTER_ERR_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic            clk;
  logic            aresetn;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic            resp_valid, resp_ready, resp_err;
  logic [DW-1:0]   resp_data;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wvalid, m_axi_wready;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic            m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;

  int checks   = 0;
  int failures = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] model[int];

  int unsigned   cycle_cnt = 0;
  int unsigned   aw_block_until = 0;
  int unsigned   w_block_until  = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  logic [1:0]    rresp_cfg = 2'b00;

  // slave-side state
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          have_aw, have_w;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  axi_sram_req_master #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .axi_aclk      (clk),
    .axi_aresetn   (aresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_axi_awready = (cycle_cnt >= aw_block_until);
  assign m_axi_wready  = (cycle_cnt >= w_block_until);
  assign m_axi_arready = 1'b1;
  assign m_axi_bresp   = bresp_cfg;

  // Behavioural AXI-Lite SRAM slave: B/R responses one cycle after handshake.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (!aresetn) begin
      have_aw      <= 1'b0;
      have_w       <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= '0;
      m_axi_rresp  <= 2'b00;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        have_aw <= 1'b1;
        wr_addr <= m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        have_w  <= 1'b1;
        wr_data <= m_axi_wdata;
      end
      if ((have_aw || (m_axi_awvalid && m_axi_awready)) &&
          (have_w  || (m_axi_wvalid  && m_axi_wready)) && !m_axi_bvalid) begin
        mem[(m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : wr_addr] <=
          (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : wr_data;
        m_axi_bvalid <= 1'b1;
        have_aw      <= 1'b0;
        have_w       <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[m_axi_araddr];
        m_axi_rresp  <= rresp_cfg;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    exp_t e;
    e.data = we ? '0 : model[int'(addr)];
    e.err  = ERR_EXP && ((we ? bresp_cfg : rresp_cfg) != AXI_RESP_OKAY);
    exp_q.push_back(e);
    if (we) model[int'(addr)] = data;
  endtask

  // Present one request, wait for it to be accepted; returns in the cycle
  // after the accepting edge.
  task automatic send_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int unsigned aw_stall,
                          input int unsigned w_stall, input bit push);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_wait actual=%b required=1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
    aw_block_until = cycle_cnt + 1 + aw_stall;
    w_block_until  = cycle_cnt + 1 + w_stall;
    if (push) push_exp(we, addr, data);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual_pending=%0d required=0", name, exp_q.size());
    end
  endtask

  // Scoreboard: compare each response handshake against the queue head.
  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (aresetn === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_resp actual data=%h err=%b required=no_response",
                   resp_data, resp_err);
        end else begin
          e = exp_q.pop_front();
          if (resp_data !== e.data || resp_err !== e.err) begin
            failures++;
            $display("FAIL sb_resp actual data=%h err=%b required data=%h err=%b",
                     resp_data, resp_err, e.data, e.err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
         m_axi_rready, resp_valid, resp_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=00000000",
               {req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                m_axi_rready, resp_valid, resp_err});
    end
    checks++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, resp_data} !== '0) begin
      failures++;
      $display("FAIL reset_data actual aw=%h ar=%h wd=%h rd=%h required=0",
               m_axi_awaddr, m_axi_araddr, m_axi_wdata, resp_data);
    end
    aresetn = 1'b1;
    cyc();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready actual=%b required=1", req_ready);
    end
  endtask

  task automatic test_write_all_ready();
    send_req(1'b1, 10'h0B0, 8'h10, 0, 0, 1'b1);
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !==
        {1'b1, 1'b1, 10'h0B0, 8'h10, 1'b1}) begin
      failures++;
      $display("FAIL wr_aw_w actual awv=%b wv=%b aw=%h wd=%h st=%b required 1 1 0b0 10 1",
               m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
    end
    cyc();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
      failures++;
      $display("FAIL wr_resp_phase actual awv/wv/bready=%b required=001",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_latency actual resp_valid=%b required=1", resp_valid);
    end
    wait_drain("wr_all_ready");
  endtask

  task automatic test_split_write();
    int hold = 0;
    send_req(1'b1, 10'h0C0, 8'h55, 4, 0, 1'b1);
    cyc();
    checks++;
    if ({m_axi_wvalid, m_axi_awvalid} !== 2'b01) begin
      failures++;
      $display("FAIL split_w_drop actual wv/awv=%b required=01",
               {m_axi_wvalid, m_axi_awvalid});
    end
    while (m_axi_awvalid === 1'b1 && hold < 10) begin
      checks++;
      if (m_axi_awaddr !== 10'h0C0 || m_axi_bready !== 1'b0) begin
        failures++;
        $display("FAIL split_aw_hold actual aw=%h bready=%b required aw=0c0 bready=0",
                 m_axi_awaddr, m_axi_bready);
      end
      hold++;
      cyc();
    end
    checks++;
    if (hold != 4 || m_axi_bready !== 1'b1) begin
      failures++;
      $display("FAIL split_aw_done actual hold=%0d bready=%b required hold=4 bready=1",
               hold, m_axi_bready);
    end
    wait_drain("split_write");
  endtask

  task automatic test_write_then_read();
    send_req(1'b1, 10'h0D1, 8'h3A, 0, 0, 1'b1);
    wait_drain("wtr_write");
    send_req(1'b0, 10'h0D1, 8'h00, 0, 0, 1'b1);
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 10'h0D1) begin
      failures++;
      $display("FAIL rd_ar actual arv=%b ar=%h required 1 0d1", m_axi_arvalid, m_axi_araddr);
    end
    cyc();
    checks++;
    if (m_axi_rready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_rready actual rready=%b arv=%b required 1 0",
               m_axi_rready, m_axi_arvalid);
    end
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 8'h3A) begin
      failures++;
      $display("FAIL rd_latency actual resp_valid=%b data=%h required 1 3a",
               resp_valid, resp_data);
    end
    wait_drain("wtr_read");
    send_req(1'b0, 10'h0C0, 8'h00, 0, 0, 1'b1);
    wait_drain("read_0c0");
  endtask

  task automatic test_backpressure();
    int n = 0;
    resp_ready = 1'b0;
    send_req(1'b0, 10'h0B0, 8'h00, 0, 0, 1'b1);
    while (resp_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    // Offer the next request while the response is stalled.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h0D1;
    req_data  = 8'h00;
    push_exp(1'b0, 10'h0D1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h10 || req_ready !== 1'b0 ||
          m_axi_arvalid !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d actual rv=%b data=%h rr=%b arv=%b required 1 10 0 0",
                 i, resp_valid, resp_data, req_ready, m_axi_arvalid);
      end
      cyc();
    end
    resp_ready = 1'b1;
    cyc();
    checks++;
    if (req_ready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle_first actual rr=%b arv=%b required 1 0",
               req_ready, m_axi_arvalid);
    end
    cyc();
    req_valid = 1'b0;
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 10'h0D1) begin
      failures++;
      $display("FAIL bp_next_accept actual arv=%b ar=%h required 1 0d1",
               m_axi_arvalid, m_axi_araddr);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_error();
    rresp_cfg = AXI_RESP_SLVERR;
    send_req(1'b0, 10'h0D1, 8'h00, 0, 0, 1'b1);
    cyc();
    cyc();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== ERR_EXP) begin
      failures++;
      $display("FAIL err_rresp actual rv=%b err=%b required 1 %b",
               resp_valid, resp_err, ERR_EXP);
    end
    wait_drain("err_read");
    rresp_cfg = AXI_RESP_OKAY;
    bresp_cfg = AXI_RESP_SLVERR;
    send_req(1'b1, 10'h0B1, 8'h99, 0, 0, 1'b1);
    wait_drain("err_write");
    bresp_cfg = AXI_RESP_OKAY;
    send_req(1'b0, 10'h0B1, 8'h00, 0, 0, 1'b1);
    wait_drain("err_clear");
  endtask

  task automatic test_reset_mid();
    send_req(1'b1, 10'h0E0, 8'h77, 3, 3, 1'b0);
    checks++;
    if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre actual awv=%b wv=%b required 1 1",
               m_axi_awvalid, m_axi_wvalid);
    end
    aresetn = 1'b0;
    cyc();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
         resp_valid} !== 6'b0 || dut.state_q !== IDLE) begin
      failures++;
      $display("FAIL rst_mid actual valids=%b state=%0d required 000000 IDLE",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                m_axi_rready, resp_valid}, dut.state_q);
    end
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_no_resp cyc=%0d actual=%b required=0", i, resp_valid);
      end
      cyc();
    end
    send_req(1'b0, 10'h0D1, 8'h00, 0, 0, 1'b1);
    wait_drain("rst_recover");
  endtask

  initial begin
    aresetn    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_write_all_ready();
    test_split_write();
    test_write_then_read();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sram_req_master.md
AXI_SRAM_REQ_MASTER -- requirements
Module: axi_sram_req_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 10, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 8, data width (multiple of 8).
REQ-003 SHALL have ports: axi_aclk  in  1  sole clock; axi_aresetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=write, 0=read); req_addr in AXI_ADDR_WIDTH; req_data in AXI_DATA_WIDTH.
REQ-005 SHALL have response ports: resp_valid out 1; resp_ready in 1; resp_data out AXI_DATA_WIDTH (read data; 0 for writes); resp_err out 1.
REQ-006 SHALL have write-address ports: m_axi_awaddr out AXI_ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-007 SHALL have write-data ports: m_axi_wdata out AXI_DATA_WIDTH; m_axi_wstrb out AXI_DATA_WIDTH/8; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-008 SHALL have write-response ports: m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-009 SHALL have read ports: m_axi_araddr out AXI_ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1; m_axi_rdata in AXI_DATA_WIDTH; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-010 SHALL convert one simple request into one AXI-Lite transaction toward axi_sram_controller; at most one transaction outstanding.
REQ-011 SHALL use states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid && req_ready, with addr/data/we registered.
REQ-013 SHALL, on accepted write, enter WR_ADDR_DATA next cycle with awvalid=1 and wvalid=1; wstrb all ones.
REQ-014 SHALL track AW and W handshakes independently: drop awvalid after awvalid&&awready, drop wvalid after wvalid&&wready; both may complete in the same cycle or in either order.
REQ-015 SHALL hold awaddr/wdata stable while the corresponding valid is high; valid never drops before ready.
REQ-016 SHALL move to WR_RESP once both handshakes are done (same cycle as the last one completes), asserting bready=1 only in WR_RESP.
REQ-017 SHALL, on bvalid&&bready, capture bresp and go to RESP.
REQ-018 SHALL, on accepted read, enter RD_ADDR with arvalid=1; on arvalid&&arready go to RD_DATA with rready=1; on rvalid&&rready capture rdata/rresp and go to RESP.
REQ-019 SHALL assert resp_valid only in RESP, holding resp_data/resp_err stable until resp_valid&&resp_ready, then return to IDLE.
REQ-020 SHALL give a minimum request-to-resp_valid latency of 3 cycles when the slave is ready on every channel (accept, AW/W, B or AR, R).
REQ-021 SHALL ignore bvalid/rvalid arriving outside WR_RESP/RD_DATA (no capture, no state change).
REQ-022 SHALL not accept a new request in the same cycle as resp handshake (IDLE first).

Reset
REQ-023 SHALL, while axi_aresetn=0 at posedge, enter IDLE and drive all valid/ready outputs 0 except req_ready (1 after first non-reset cycle), resp_data=0, resp_err=0, addresses/wdata=0.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation; no response is produced for it.

Configuration
REQ-025 SHALL, with AXI_SRAM_REQ_MASTER_ERR_EN defined, set resp_err=1 when captured bresp/rresp is not 2'b00.
REQ-026 SHALL, without AXI_SRAM_REQ_MASTER_ERR_EN, tie resp_err to 0 and not store resp codes.

Structure
REQ-027 SHALL take state encoding and AXI resp constants (OKAY=2'b00, SLVERR=2'b10) from a shared axi_lite_pkg.
REQ-028 SHALL be a single flat FSM module; no sub-module is natural.

Verification
REQ-029 SHALL cover write, all slaves ready: req we=1 addr=0x0B0 data=0x10 -> AW/W handshake same cycle, bresp=00, resp_valid 3 cycles after accept, resp_err=0.
REQ-030 SHALL cover split write: awready held 0 four cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held with awaddr=0x0C0 stable, bready only after AW done.
REQ-031 SHALL cover write-then-read: write 0x3A to 0x0D1, read 0x0D1 -> resp_data=0x3A through axi_sram_controller plus sram_model.
REQ-032 SHALL cover backpressure: resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0 throughout.
REQ-033 SHALL cover error (macro defined): rresp=2'b10 -> resp_err=1; same stimulus without macro -> resp_err=0.
REQ-034 SHALL cover reset in WR_ADDR_DATA -> next cycle all m_axi valids 0, resp_valid 0, state IDLE.
